uart_tx_device: RTL

Bus-attached UART transmitter that sits directly downstream of the simple Ibex bus as one of its devices. It accepts byte writes into a transmit FIFO and serialises them as 8N1 frames on a single TX pin. It answers every request exactly one cycle later, as the bus requires. A STATUS register and a level interrupt let software poll or wait for drain.

---
 rtl/uart_tx_device.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_device.sv
// Bus-attached 8N1 UART transmitter: byte FIFO, STATUS/CTRL registers, and a
// drain interrupt. Every bus request is answered on the following cycle.
module uart_tx_device #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned FifoDepth    = 8,
  parameter int unsigned ClkDiv       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    device_req_i,
  input  logic [AddressWidth-1:0] device_addr_i,
  input  logic                    device_we_i,
  input  logic [DataWidth/8-1:0]  device_be_i,
  input  logic [DataWidth-1:0]    device_wdata_i,
  output logic                    device_rvalid_o,
  output logic [DataWidth-1:0]    device_rdata_o,
  output logic                    device_err_o,
  output logic                    uart_tx_o,
  output logic                    irq_o
);
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned LvlW = $clog2(FifoDepth + 1);
  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] BaudMax = CntW'(ClkDiv - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FifoDepth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  typedef enum logic [1:0] {RegTxData, RegStatus, RegCtrl, RegRsvd} reg_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic [7:0]        mem_q [FifoDepth];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [LvlW-1:0]   level_q;
  logic              full, empty, push_req, push, pop, busy;

  logic              tx_en_q, irq_en_q, ctrl_we;
  logic              rvalid_q, err_q, err_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  reg_e              reg_sel;
  logic              unused_bits;

  assign reg_sel     = reg_e'(device_addr_i[3:2]);
  assign full        = (level_q == LvlFull);
  assign empty       = (level_q == '0);
  assign unused_bits = ^{device_addr_i[AddressWidth-1:4], device_addr_i[1:0],
                         device_be_i[DataWidth/8-1:1], device_wdata_i[DataWidth-1:8]};

  // Bus decode; overflow is judged on the level at the start of the cycle.
  always_comb begin
    rdata_d  = '0;
    err_d    = 1'b0;
    push_req = 1'b0;
    ctrl_we  = 1'b0;
    if (device_req_i) begin
      unique case (reg_sel)
        RegTxData: push_req = device_we_i & device_be_i[0];
        RegStatus: begin
          if (device_we_i) err_d = 1'b1;
          else rdata_d[15:0] = {8'(level_q), 5'b0, busy, empty, full};
        end
        RegCtrl: begin
          if (device_we_i) ctrl_we = device_be_i[0];
          else rdata_d[1:0] = {irq_en_q, tx_en_q};
        end
        RegRsvd: err_d = 1'b1;
      endcase
      if (push_req && full) err_d = 1'b1;
    end
  end

  assign push = push_req & ~full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
    end else begin
      rvalid_q <= device_req_i;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      if (ctrl_we) begin
        tx_en_q  <= device_wdata_i[0];
        irq_en_q <= device_wdata_i[1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= device_wdata_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      level_q <= level_q + LvlW'(push) - LvlW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_en_q && !empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          baud_d  = BaudMax;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d    = BaudMax;
          bit_idx_d = '0;
          state_d   = DATA;
        end else baud_d = baud_q - CntW'(1);
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d  = BaudMax;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else baud_d = baud_q - CntW'(1);
      end
      STOP: begin
        if (baud_q == '0) begin
          if (tx_en_q && !empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            baud_d  = BaudMax;
            state_d = START;
          end else state_d = IDLE;
        end else baud_d = baud_q - CntW'(1);
      end
    endcase
  end

  // The pin is registered from the next state so it lines up with state_q.
  always_comb begin
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy  = (state_q != IDLE);
    irq_o = empty & ~busy & irq_en_q;
  end

  assign uart_tx_o       = tx_q;
  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign device_err_o    = err_q;

endmodule
